// File: rtl/alu_stack_sequencer.sv
// alu_stack_sequencer
//   Owns a hardware operand stack and sequences an external 16-bit
//   combinational ALU for stack instructions (PUSH, POP, DUP, ADD, SUB,
//   MUL, DIV). DIV is a 16-step restoring division that uses the ALU's SUB
//   function for every trial subtraction.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    command handshake (see below)
//   cmd_op [2:0]       0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 DUP, 7 illegal
//   cmd_data [15:0]    PUSH immediate, sampled at accept
//   alu_func [3:0]     0 pass i0, 1 pass i1, 2 add, 3 sub, 4 mul
//   alu_i0/alu_i1      ALU operands
//   alu_o0             ALU result (combinational from func/i0/i1)
//   top [15:0]         top of stack, 0 when empty
//   depth [DW-1:0]     number of valid entries
//   busy               command in flight (= !cmd_ready)
//   done / err         one-cycle completion / rejection pulses
//   err_code [1:0]     0 underflow, 1 overflow, 2 divide by zero, 3 illegal op
//   fsm_state [1:0]    debug view of the sequencer state (0 IDLE, 1 EXEC, 2 DIV)
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; cmd_valid seen
// while busy is ignored and the command stays with the sender.
module alu_stack_sequencer #(
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [15:0]   cmd_data,
  output logic [3:0]    alu_func,
  output logic [15:0]   alu_i0,
  output logic [15:0]   alu_i1,
  input  logic [15:0]   alu_o0,
  output logic [15:0]   top,
  output logic [DW-1:0] depth,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [1:0]    fsm_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] ERR_UFL = 2'd0;
  localparam logic [1:0] ERR_OFL = 2'd1;
  localparam logic [1:0] ERR_DZ  = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  localparam logic [3:0] F_PASS0 = 4'd0;
  localparam logic [3:0] F_PASS1 = 4'd1;
  localparam logic [3:0] F_ADD   = 4'd2;
  localparam logic [3:0] F_SUB   = 4'd3;
  localparam logic [3:0] F_MUL   = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   stk [DEPTH];
  logic [DW-1:0] depth_q;
  logic [2:0]    op_q;
  logic [15:0]   data_q;
  logic          done_q, err_q;
  logic [1:0]    err_code_q;

  // Division registers. The stored partial remainder is always below the
  // divisor after each step, so its 17th bit is always zero and only the
  // shifted trial value R' needs the extra bit.
  logic [15:0]   dividend_q, divisor_q, rem_q, quo_q;
  logic [3:0]    cnt_q;
  logic [16:0]   r_sh;
  logic          trial_ge;
  logic [15:0]   quo_next;

  logic [AW-1:0] idx_tos, idx_nos, idx_new;
  logic [15:0]   tos, nos;
  logic          is_binary;
  logic          err_det;
  logic [1:0]    err_kind;

  // Stack addressing; reads are guarded so an empty or single-entry stack
  // never presents stale contents.
  assign idx_tos = AW'(depth_q - DW'(1));
  assign idx_nos = AW'(depth_q - DW'(2));
  assign idx_new = AW'(depth_q);
  assign tos     = (depth_q != '0)      ? stk[idx_tos] : '0;
  assign nos     = (depth_q >= DW'(2))  ? stk[idx_nos] : '0;

  assign is_binary = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                     (op_q == OP_MUL) || (op_q == OP_DIV);

  // Error detection in priority order; only consulted while in EXEC.
  always_comb begin
    err_det  = 1'b0;
    err_kind = ERR_UFL;
    if (op_q == OP_ILL) begin
      err_det  = 1'b1;
      err_kind = ERR_ILL;
    end else if ((((op_q == OP_POP) || (op_q == OP_DUP)) && (depth_q == '0)) ||
                 (is_binary && (depth_q < DW'(2)))) begin
      err_det  = 1'b1;
      err_kind = ERR_UFL;
    end else if (((op_q == OP_PUSH) || (op_q == OP_DUP)) && (depth_q == DW'(DEPTH))) begin
      err_det  = 1'b1;
      err_kind = ERR_OFL;
    end else if ((op_q == OP_DIV) && (tos == '0)) begin
      err_det  = 1'b1;
      err_kind = ERR_DZ;
    end
  end

  // Restoring division step: shift in the next dividend bit, then keep the
  // ALU difference only if the trial value reaches the divisor. A set
  // R'[16] means R' already exceeds any 16-bit divisor, and the 16-bit ALU
  // difference is still exact because the true result is below the divisor.
  assign r_sh     = {rem_q, dividend_q[cnt_q]};
  assign trial_ge = r_sh[16] | (r_sh[15:0] >= divisor_q);

  always_comb begin
    quo_next        = quo_q;
    quo_next[cnt_q] = trial_ge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and ALU drive.
  always_comb begin
    state_d  = state_q;
    alu_func = F_PASS0;
    alu_i0   = '0;
    alu_i1   = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_PUSH: begin alu_func = F_PASS1; alu_i1 = data_q; end
          OP_DUP:  begin alu_func = F_PASS1; alu_i1 = tos;    end
          OP_ADD:  begin alu_func = F_ADD; alu_i0 = nos; alu_i1 = tos; end
          OP_SUB:  begin alu_func = F_SUB; alu_i0 = nos; alu_i1 = tos; end
          OP_MUL:  begin alu_func = F_MUL; alu_i0 = nos; alu_i1 = tos; end
          default: ;
        endcase
        if (!err_det && (op_q == OP_DIV)) state_d = S_DIV;
        else                              state_d = S_IDLE;
      end
      S_DIV: begin
        alu_func = F_SUB;
        alu_i0   = r_sh[15:0];
        alu_i1   = divisor_q;
        if (cnt_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: command latch, stack updates, division registers, pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      depth_q    <= '0;
      op_q       <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
          end
        end
        S_EXEC: begin
          if (err_det) begin
            err_q      <= 1'b1;
            err_code_q <= err_kind;
          end else begin
            case (op_q)
              OP_PUSH, OP_DUP: begin
                stk[idx_new] <= alu_o0;
                depth_q      <= depth_q + DW'(1);
                done_q       <= 1'b1;
              end
              OP_POP: begin
                depth_q <= depth_q - DW'(1);
                done_q  <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_MUL: begin
                stk[idx_nos] <= alu_o0;
                depth_q      <= depth_q - DW'(1);
                done_q       <= 1'b1;
              end
              OP_DIV: begin
                dividend_q <= nos;
                divisor_q  <= tos;
                rem_q      <= '0;
                quo_q      <= '0;
                cnt_q      <= 4'd15;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          rem_q <= trial_ge ? alu_o0 : r_sh[15:0];
          quo_q <= quo_next;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            stk[idx_nos] <= quo_next;
            depth_q      <= depth_q - DW'(1);
            done_q       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign top       = tos;
  assign depth     = depth_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Testbench for alu_stack_sequencer: directed steps from the test plan plus
// a randomized command stream, all checked against a queue-based stack model
// that applies the instruction rules with plain integer arithmetic.
module tb_alu_stack_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op    = '0;
  logic [15:0]   cmd_data  = '0;
  logic [3:0]    alu_func;
  logic [15:0]   alu_i0, alu_i1, alu_o0;
  logic [15:0]   top;
  logic [DW-1:0] depth;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [1:0]    fsm_state;

  alu_stack_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_func(alu_func), .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_o0(alu_o0),
    .top(top), .depth(depth), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .fsm_state(fsm_state)
  );

  // Combinational ALU the sequencer drives.
  always_comb begin
    case (alu_func)
      4'd0:    alu_o0 = alu_i0;
      4'd1:    alu_o0 = alu_i1;
      4'd2:    alu_o0 = alu_i0 + alu_i1;
      4'd3:    alu_o0 = alu_i0 - alu_i1;
      4'd4:    alu_o0 = alu_i0 * alu_i1;
      default: alu_o0 = '0;
    endcase
  end

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  // Expected entry: {err, done, err_code, depth[7:0], top[15:0]}
  logic [27:0] exp_q[$];
  logic [15:0] model_stk[$];
  logic [1:0]  model_code = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_top();
    if (model_stk.size() == 0) return 16'd0;
    return model_stk[model_stk.size() - 1];
  endfunction

  // Reference behaviour of one command; pushes the expected outcome.
  task automatic model_step(input logic [2:0] op, input logic [15:0] data,
                            output int exp_lat, output int exp_func);
    int          n;
    bit          e;
    logic [1:0]  c;
    longint      a, b, r;
    logic [15:0] tmp;
    n = model_stk.size();
    e = 1'b1;
    c = 2'd0;
    exp_func = -1;
    if (op == 3'd7) c = 2'd3;
    else if ((((op == 3'd1) || (op == 3'd6)) && n == 0) ||
             (op >= 3'd2 && op <= 3'd5 && n < 2)) c = 2'd0;
    else if (((op == 3'd0) || (op == 3'd6)) && n == DEPTH) c = 2'd1;
    else if (op == 3'd5 && model_stk[n-1] == 16'd0) c = 2'd2;
    else begin
      e = 1'b0;
      case (op)
        3'd0: begin model_stk.push_back(data); exp_func = 1; end
        3'd1: begin tmp = model_stk.pop_back(); exp_func = 0; end
        3'd6: begin tmp = model_stk[n-1]; model_stk.push_back(tmp); exp_func = 1; end
        default: begin
          tmp = model_stk.pop_back(); b = longint'(tmp);
          tmp = model_stk.pop_back(); a = longint'(tmp);
          case (op)
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = a * b;
            default: r = a / b;
          endcase
          model_stk.push_back(16'(r));
          if (op != 3'd5) exp_func = int'(op);
        end
      endcase
    end
    if (e) model_code = c;
    exp_lat = (!e && op == 3'd5) ? 18 : 2;
    exp_q.push_back({e, !e, model_code, 8'(model_stk.size()), model_top()});
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    model_stk.delete();
    model_code = 2'd0;
  endtask

  // Issue one command, wait (bounded) for done/err, compare with the model.
  // With hold set, cmd_valid stays high while the sequencer is busy.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] data,
                         input bit hold, input string tag);
    logic [27:0] exp;
    int          exp_lat, exp_func, lat;
    bit          got_done, got_err;
    logic [3:0]  exec_func;
    model_step(op, data, exp_lat, exp_func);
    @(negedge clk);
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " pulse_clear"}, 32'({done, err}), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    lat = 0; got_done = 1'b0; got_err = 1'b0; exec_func = '0;
    while (lat < 30 && !got_done && !got_err) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        exec_func = alu_func;
        if (!hold) cmd_valid = 1'b0;
      end
      if (done || err) begin
        got_done  = done;
        got_err   = err;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " status"},   32'({got_err, got_done}), 32'(exp[27:26]));
    check({tag, " latency"},  32'(lat),                 32'(exp_lat));
    check({tag, " err_code"}, 32'(err_code),            32'(exp[25:24]));
    check({tag, " depth"},    32'(depth),               32'(exp[23:16]));
    check({tag, " top"},      32'(top),                 32'(exp[15:0]));
    if (exp_func >= 0) check({tag, " exec_func"}, 32'(exec_func), 32'(exp_func));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          r;
    logic [2:0]  op;
    logic [15:0] d;
    int          lat;
    bit          seen_done;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst depth",    32'(depth),     32'd0);
    check("rst top",      32'(top),       32'd0);
    check("rst ready",    32'(cmd_ready), 32'd1);
    check("rst busy",     32'(busy),      32'd0);
    check("rst done_err", 32'({done, err}), 32'd0);
    check("rst err_code", 32'(err_code),  32'd0);
    check("rst alu",      32'({alu_func, alu_i0, alu_i1}), 32'd0);
    rst_n = 1'b1;

    // SUB in both operand orders.
    run_cmd(3'd0, 16'd7, 1'b0, "push7");
    run_cmd(3'd0, 16'd3, 1'b0, "push3");
    run_cmd(3'd3, 16'd0, 1'b0, "sub_7_3");
    check("sub_7_3 top4", 32'(top), 32'd4);
    check("sub_7_3 depth1", 32'(depth), 32'd1);
    do_reset();
    run_cmd(3'd0, 16'd3, 1'b0, "push3b");
    run_cmd(3'd0, 16'd7, 1'b0, "push7b");
    run_cmd(3'd3, 16'd0, 1'b0, "sub_3_7");
    check("sub_3_7 wrap", 32'(top), 32'h0000FFFC);

    // MUL wraps modulo 2^16.
    do_reset();
    run_cmd(3'd0, 16'd300, 1'b0, "push300a");
    run_cmd(3'd0, 16'd300, 1'b0, "push300b");
    run_cmd(3'd4, 16'd0, 1'b0, "mul");
    check("mul top", 32'(top), 32'd24464);

    // DIV, including a trial value with R'[16] set.
    do_reset();
    run_cmd(3'd0, 16'd1000, 1'b0, "push1000");
    run_cmd(3'd0, 16'd7, 1'b0, "push7c");
    run_cmd(3'd5, 16'd0, 1'b0, "div_1000_7");
    check("div top142", 32'(top), 32'd142);
    run_cmd(3'd0, 16'hFFFF, 1'b0, "pushffff");
    run_cmd(3'd0, 16'h8001, 1'b0, "push8001");
    run_cmd(3'd5, 16'd0, 1'b0, "div_ffff_8001");
    check("div r16 top1", 32'(top), 32'd1);

    // Error cases.
    do_reset();
    run_cmd(3'd0, 16'd5, 1'b0, "push5");
    run_cmd(3'd0, 16'd0, 1'b0, "push0");
    run_cmd(3'd5, 16'd0, 1'b0, "div_by_zero");
    check("dz code", 32'(err_code), 32'd2);
    do_reset();
    run_cmd(3'd1, 16'd0, 1'b0, "pop_empty");
    check("ufl code", 32'(err_code), 32'd0);
    run_cmd(3'd7, 16'd0, 1'b0, "illegal");
    check("ill code", 32'(err_code), 32'd3);
    run_cmd(3'd6, 16'd0, 1'b0, "dup_empty");

    // Overflow with DEPTH pushes; one push holds cmd_valid through busy.
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++)
      run_cmd(3'd0, 16'(i * 11), (i == 3), $sformatf("fill%0d", i));
    check("ofl code", 32'(err_code), 32'd1);
    check("ofl depth", 32'(depth), 32'(DEPTH));
    check("ofl top", 32'(top), 32'(DEPTH * 11));
    run_cmd(3'd6, 16'd0, 1'b0, "dup_full");

    // Reset asserted during DIV step 8: abort without any pulse.
    do_reset();
    run_cmd(3'd0, 16'd1000, 1'b0, "pre_div_a");
    run_cmd(3'd0, 16'd7, 1'b0, "pre_div_b");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = '0;
    @(posedge clk);
    seen_done = 1'b0;
    lat = 0;
    while (lat < 9) begin
      @(negedge clk);
      lat++;
      cmd_valid = 1'b0;
      if (done || err) seen_done = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort no_pulse_before", 32'(seen_done), 32'd0);
    check("abort depth", 32'(depth), 32'd0);
    check("abort ready", 32'(cmd_ready), 32'd1);
    check("abort pulses", 32'({done, err}), 32'd0);
    check("abort top", 32'(top), 32'd0);
    check("abort alu", 32'({alu_func, alu_i0, alu_i1}), 32'd0);
    rst_n = 1'b1;
    model_stk.delete();
    model_code = 2'd0;
    run_cmd(3'd0, 16'd9, 1'b0, "post_abort_push9");
    check("post_abort top9", 32'(top), 32'd9);

    // Randomized command stream against the model.
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 35) op = 3'd0;
      else if (r < 45) op = 3'd1;
      else if (r < 55) op = 3'd2;
      else if (r < 63) op = 3'd3;
      else if (r < 71) op = 3'd4;
      else if (r < 83) op = 3'd5;
      else if (r < 93) op = 3'd6;
      else             op = 3'd7;
      if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(0, 3));
      else                           d = 16'($urandom);
      run_cmd(op, d, ($urandom_range(0, 7) == 0), $sformatf("rnd%0d op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound in case the sequencer wedges somewhere unexpected.
  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_stack_sequencer.md
# alu_stack_sequencer

Command-driven execution unit that owns a hardware operand stack and sequences the 16-bit combinational ALU for stack instructions (PUSH, POP, DUP, ADD, SUB, MUL, DIV). It sits between instruction decode and the ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU function code and operands. Results are written back to the stack. The ALU has no divide, so DIV runs as a 16-step restoring division that uses the ALU's SUB function for each trial subtraction.

## Interface
- DEPTH, 8: operand stack entries, range 2..64.
- DW, derived as $clog2(DEPTH+1): width of `depth`.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command. High only in IDLE.
- cmd_op  in  3  opcode. 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 DUP, 7 illegal.
- cmd_data  in  16  PUSH immediate, sampled at accept.
- alu_func  out  4  ALU function code. 0 pass i0, 1 pass i1, 2 add, 3 sub, 4 mul.
- alu_i0  out  16  ALU operand 0.
- alu_i1  out  16  ALU operand 1.
- alu_o0  in  16  ALU result, combinational from alu_func/alu_i0/alu_i1.
- top  out  16  current top of stack (TOS). Value is 0 when depth = 0.
- depth  out  DW  number of valid entries.
- busy  out  1  command in flight. Equal to !cmd_ready.
- done  out  1  one-cycle pulse: command completed successfully.
- err  out  1  one-cycle pulse: command rejected.
- err_code  out  2  reason for err. 0 underflow, 1 overflow, 2 divide by zero, 3 illegal op. Held until the next err.

## Operation
- Accept: cmd_valid && cmd_ready at a rising edge. The sequencer latches op and data, then moves IDLE→EXEC.
- States and transitions:
  - IDLE → EXEC on accept.
  - EXEC → IDLE, except a valid DIV.
  - EXEC → DIV for a valid DIV.
  - DIV → IDLE after 16 steps.
- Operand naming: NOS is the entry below TOS. Binary ops drive alu_i0 = NOS and alu_i1 = TOS. SUB computes NOS−TOS.
- EXEC, per opcode:
  - ADD, SUB, MUL: alu_func = 2, 3 or 4. alu_o0 replaces NOS; the stack pops one, so depth decreases by 1.
  - PUSH: alu_func = 1, alu_i1 = latched data. alu_o0 is pushed.
  - DUP: alu_func = 1, alu_i1 = TOS. alu_o0 is pushed.
  - POP: alu_func = 0, no ALU use. depth decreases by 1.
  - DIV: latch dividend = NOS and divisor = TOS, clear the 17-bit partial remainder R and the count.
- Arithmetic is unsigned, modulo 2^16. MUL keeps the low 16 bits, exactly as the ALU returns them.
- DIV step k (k = 15..0), one per cycle:
  - R' = {R[15:0], dividend[k]}.
  - Drive alu_func = 3, alu_i0 = R'[15:0], alu_i1 = divisor.
  - If R' ≥ divisor (17-bit compare; true whenever R'[16] = 1): R ← {1'b0, alu_o0} and q[k] = 1.
  - Otherwise: R ← R' and q[k] = 0.
  - After step 0, the quotient replaces NOS and the stack pops one. The remainder is discarded.
- Error checks run in EXEC, in priority order:
  1. Illegal op.
  2. Underflow: POP or DUP with depth = 0; binary op with depth < 2.
  3. Overflow: PUSH or DUP with depth = DEPTH.
  4. Divide by zero: DIV with TOS = 0.
- On any error, the stack is unchanged, err pulses, and the sequencer returns to IDLE.
- Outside EXEC and DIV, alu_func = 0 and alu_i0 = alu_i1 = 0.
- cmd_valid while busy is ignored; the command is not consumed.

## Timing
- Reset values: depth 0, top 0, cmd_ready 1, busy 0, done 0, err 0, err_code 0, alu_func 0, alu_i0 0, alu_i1 0.
- Stack contents are cleared by reset.
- Accept at edge N:
  - EXEC occupies cycle N+1.
  - Non-DIV ops: stack/top/depth update and done (or err) pulse are visible after edge N+2. cmd_ready is high again in that same cycle.
  - Throughput: one command per 2 cycles.
- DIV:
  - EXEC at N+1, steps at N+2..N+17.
  - Result and done visible after edge N+18.
  - Error cases, including divide by zero, report at N+2.
- done and err are mutually exclusive and never held longer than one cycle.
- rst_n assertion mid-command (including mid-DIV): immediate abort. All outputs return to their reset values, with no done or err pulse.

## Test plan
- PUSH 7, PUSH 3, SUB → done 2 cycles after SUB accept; top = 4, depth = 1. Separately, PUSH 3, PUSH 7, SUB → top = 0xFFFC.
- PUSH 300, PUSH 300, MUL → top = 24464 (90000 mod 65536), depth = 1. alu_func = 4 during EXEC.
- PUSH 1000, PUSH 7, DIV → done exactly 18 cycles after accept, top = 142. Then PUSH 0xFFFF, PUSH 0x8001, DIV → top = 1 (exercises R'[16]).
- PUSH 5, PUSH 0, DIV → err at accept+2, err_code = 2, depth = 2, top = 0. POP on an empty stack → err_code = 0. Opcode 7 → err_code = 3.
- DEPTH = 8: nine PUSHes → the ninth gives err with err_code = 1; depth stays 8 and top equals the eighth value. cmd_valid held during busy consumes no extra commands.
- Assert rst_n low during DIV step 8 → next cycle depth = 0, cmd_ready = 1, no done. A following PUSH 9 gives top = 9.
